// File: rtl/formula_nested_sqrt_pipe.sv
// Nested-root pipeline: res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N_TERMS-1]))).
// One vector per clock, fixed latency N_TERMS*(ISQRT_LAT+1), saturating sums, tag forwarded.

module isqrt_pipe #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);
  localparam int H = WIDTH / 2;
  localparam int R = H + 2;

  logic [H-1:0]     vld_q;
  logic [H-1:0]     stg_vld;
  logic [R-1:0]     rem_q   [H];
  logic [H-1:0]     root_q  [H];
  logic [WIDTH-1:0] rad_q   [H];
  logic [R-1:0]     rem_in  [H];
  logic [H-1:0]     root_in [H];
  logic [WIDTH-1:0] rad_in  [H];
  logic [R-1:0]     rem_d   [H];
  logic [H-1:0]     root_d  [H];
  logic [WIDTH-1:0] rad_d   [H];
  logic [R-1:0]     rem_sh;
  logic [R-1:0]     trial;

  assign stg_vld = H'({vld_q, x_vld});

  always_comb begin
    rem_in[0]  = '0;
    root_in[0] = '0;
    rad_in[0]  = x;
    for (int s = 1; s < H; s++) begin
      rem_in[s]  = rem_q[s-1];
      root_in[s] = root_q[s-1];
      rad_in[s]  = rad_q[s-1];
    end
  end

  // One result bit per stage: bring down the next two radicand bits, try root*4+1.
  always_comb begin
    rem_sh = '0;
    trial  = '0;
    for (int s = 0; s < H; s++) begin
      rem_sh = R'({rem_in[s], rad_in[s][WIDTH-1 -: 2]});
      trial  = {root_in[s], 2'b01};
      if (rem_sh >= trial) begin
        rem_d[s]  = rem_sh - trial;
        root_d[s] = H'({root_in[s], 1'b1});
      end else begin
        rem_d[s]  = rem_sh;
        root_d[s] = H'({root_in[s], 1'b0});
      end
      rad_d[s] = {rad_in[s][WIDTH-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= stg_vld;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < H; s++) begin
      if (stg_vld[s]) begin
        rem_q[s]  <= rem_d[s];
        root_q[s] <= root_d[s];
        rad_q[s]  <= rad_d[s];
      end
    end
  end

  assign y_vld = vld_q[H-1];
  assign y     = root_q[H-1];
endmodule

module fnsp_delay_line #(
  parameter int DW    = 1,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [DW-1:0] d_i,
  output logic          vld_o,
  output logic [DW-1:0] d_o
);
  logic [DEPTH-1:0] vld_q;
  logic [DW-1:0]    d_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= DEPTH'({vld_q, vld_i});
    end
  end

  // Each tap moves only when the word it receives is valid.
  always_ff @(posedge clk) begin
    if (vld_i) begin
      d_q[0] <= d_i;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (vld_q[i-1]) begin
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign d_o   = d_q[DEPTH-1];
endmodule

module formula_nested_sqrt_pipe #(
  parameter int WIDTH     = 32,
  parameter int N_TERMS   = 3,
  parameter int ISQRT_LAT = 16,
  parameter int TAG_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arg_vld,
  input  logic [N_TERMS*WIDTH-1:0]   args,
  input  logic [TAG_W-1:0]           arg_tag,
  output logic                       res_vld,
  output logic [WIDTH/2-1:0]         res,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_sat
);
  localparam int H         = WIDTH / 2;
  localparam int STAGE_LAT = ISQRT_LAT + 1;

  logic [N_TERMS-1:0]   sq_vld;
  logic [N_TERMS*H-1:0] sq_y;
  logic [N_TERMS-1:0]   sq_sat;

  for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
    if (gi == 0) begin : g_first
      isqrt_pipe #(.WIDTH(WIDTH)) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .x_vld (arg_vld),
        .x     (args[(N_TERMS-1)*WIDTH +: WIDTH]),
        .y_vld (sq_vld[0]),
        .y     (sq_y[0 +: H])
      );
      assign sq_sat[0] = 1'b0;
    end else begin : g_nest
      logic             x_vld_dl;
      logic [WIDTH-1:0] x_dl;
      logic             add_en;
      logic [WIDTH:0]   sum_full;
      logic [WIDTH-1:0] sum_d;
      logic             add_vld_q;
      logic [WIDTH-1:0] add_q;
      logic             add_sat_q;
      logic             sat_vld_dl;
      logic             sat_dl;

      // The operand waits exactly as long as the inner terms take to reach this adder.
      fnsp_delay_line #(.DW(WIDTH), .DEPTH(gi*STAGE_LAT-1)) u_x_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (arg_vld),
        .d_i   (args[(N_TERMS-1-gi)*WIDTH +: WIDTH]),
        .vld_o (x_vld_dl),
        .d_o   (x_dl)
      );

      assign add_en   = sq_vld[gi-1] & x_vld_dl;
      assign sum_full = {1'b0, x_dl} + {{(WIDTH-H+1){1'b0}}, sq_y[(gi-1)*H +: H]};
      assign sum_d    = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          add_vld_q <= 1'b0;
        end else begin
          add_vld_q <= add_en;
        end
      end

      always_ff @(posedge clk) begin
        if (add_en) begin
          add_q     <= sum_d;
          add_sat_q <= sq_sat[gi-1] | sum_full[WIDTH];
        end
      end

      isqrt_pipe #(.WIDTH(WIDTH)) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .x_vld (add_vld_q),
        .x     (add_q),
        .y_vld (sq_vld[gi]),
        .y     (sq_y[gi*H +: H])
      );

      fnsp_delay_line #(.DW(1), .DEPTH(ISQRT_LAT)) u_sat_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (add_vld_q),
        .d_i   (add_sat_q),
        .vld_o (sat_vld_dl),
        .d_o   (sat_dl)
      );

      assign sq_sat[gi] = sat_vld_dl & sat_dl;
    end
  end

  logic             tag_vld_dl;
  logic [TAG_W-1:0] tag_dl;
  logic             out_en;
  logic             res_vld_q;
  logic [H-1:0]     res_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_sat_q;

  fnsp_delay_line #(.DW(TAG_W), .DEPTH(N_TERMS*STAGE_LAT-1)) u_tag_dl (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (arg_vld),
    .d_i   (arg_tag),
    .vld_o (tag_vld_dl),
    .d_o   (tag_dl)
  );

  assign out_en = sq_vld[N_TERMS-1] & tag_vld_dl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_tag_q <= '0;
      res_sat_q <= 1'b0;
    end else begin
      res_vld_q <= out_en;
      if (out_en) begin
        res_q     <= sq_y[(N_TERMS-1)*H +: H];
        res_tag_q <= tag_dl;
        res_sat_q <= sq_sat[N_TERMS-1];
      end
    end
  end

  assign res_vld = res_vld_q;
  assign res     = res_q;
  assign res_tag = res_tag_q;
  assign res_sat = res_sat_q;
endmodule

// File: tb/tb_formula_nested_sqrt_pipe.sv
// Bench for formula_nested_sqrt_pipe: directed vector table, random streams and reset
// sequences, all checked against a plain-arithmetic scoreboard with exact result timing.

module tb_formula_nested_sqrt_pipe;
  localparam int WIDTH     = 32;
  localparam int N_TERMS   = 3;
  localparam int ISQRT_LAT = 16;
  localparam int TAG_W     = 4;
  localparam int LAT       = N_TERMS * (ISQRT_LAT + 1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     arg_vld = 1'b0;
  logic [N_TERMS*WIDTH-1:0] args = '0;
  logic [TAG_W-1:0]         arg_tag = '0;
  logic                     res_vld;
  logic [WIDTH/2-1:0]       res;
  logic [TAG_W-1:0]         res_tag;
  logic                     res_sat;

  always #5 clk = ~clk;

  formula_nested_sqrt_pipe #(
    .WIDTH(WIDTH), .N_TERMS(N_TERMS), .ISQRT_LAT(ISQRT_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arg_vld (arg_vld),
    .args    (args),
    .arg_tag (arg_tag),
    .res_vld (res_vld),
    .res     (res),
    .res_tag (res_tag),
    .res_sat (res_sat)
  );

  typedef struct {
    int          due;
    logic [15:0] res;
    logic [3:0]  tag;
    logic        sat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        sat;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl [10];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] last_res = '0;
  logic [3:0]  last_tag = '0;
  logic        last_sat = 1'b0;
  logic        mon_exp_vld;
  exp_t        mon_e;
  logic [3:0]  tag_cnt = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_isqrt(input longint unsigned v);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[15:0];
  endfunction

  // Evaluate the nested formula innermost-first with 64-bit sums clamped to 32 bits.
  function automatic void ref_model(input logic [N_TERMS*WIDTH-1:0] v,
                                    output logic [15:0] r, output logic s);
    longint unsigned acc;
    longint unsigned sum;
    s   = 1'b0;
    acc = 64'(ref_isqrt(64'(v[(N_TERMS-1)*WIDTH +: WIDTH])));
    for (int j = N_TERMS - 2; j >= 0; j--) begin
      sum = 64'(v[j*WIDTH +: WIDTH]) + acc;
      if (sum > 64'h0000_0000_FFFF_FFFF) begin
        sum = 64'h0000_0000_FFFF_FFFF;
        s   = 1'b1;
      end
      acc = 64'(ref_isqrt(sum));
    end
    r = acc[15:0];
  endfunction

  function automatic logic [31:0] rand_arg();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 70000));
      1:       v = 32'($urandom_range(0, 300));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [3:0] tag,
                       input logic [15:0] er, input logic es);
    @(negedge clk);
    arg_vld = vld;
    args    = {c, b, a};
    arg_tag = tag;
    if (vld) sb.push_back('{due: cyc + LAT, res: er, tag: tag, sat: es});
  endtask

  task automatic drive_idle();
    drive(1'b0, $urandom, $urandom, $urandom, 4'($urandom), 16'd0, 1'b0);
  endtask

  task automatic drive_rand(input logic vld);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [15:0] r;
    logic        s;
    a = rand_arg();
    b = rand_arg();
    c = rand_arg();
    ref_model({c, b, a}, r, s);
    drive(vld, a, b, c, tag_cnt, r, s);
    if (vld) tag_cnt = tag_cnt + 4'd1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < LAT + 20) begin
      drive_idle();
      n++;
    end
    drive_idle();
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    arg_vld = 1'b0;
    sb.delete();
    last_res = '0;
    last_tag = '0;
    last_sat = 1'b0;
    #1;
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_res_sat", 32'(res_sat), 32'd0);
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Every active cycle: res_vld must match the scoreboard timing; outputs must equal the
  // latest retired expectation (which also covers holding during gaps).
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) mon_e = sb.pop_front();
      mon_exp_vld = (sb.size() > 0) && (sb[0].due == cyc);
      chk("res_vld", 32'(res_vld), 32'(mon_exp_vld));
      if (mon_exp_vld) begin
        mon_e    = sb.pop_front();
        last_res = mon_e.res;
        last_tag = mon_e.tag;
        last_sat = mon_e.sat;
      end
      chk("res", 32'(res), 32'(last_res));
      chk("res_tag", 32'(res_tag), 32'(last_tag));
      chk("res_sat", 32'(res_sat), 32'(last_sat));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'd0,          32'd0,          32'd16,         4'd5,  16'd1,      1'b0};
    tbl[1] = '{32'd13,         32'd9,          32'd0,          4'd1,  16'd4,      1'b0};
    tbl[2] = '{32'hFFFF_FFFF,  32'd0,          32'd0,          4'd2,  16'hFFFF,   1'b0};
    tbl[3] = '{32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd3,  16'd255,    1'b1};
    tbl[4] = '{32'd100,        32'd0,          32'd0,          4'd4,  16'd10,     1'b0};
    tbl[5] = '{32'd1,          32'd1,          32'd1,          4'd6,  16'd1,      1'b0};
    tbl[6] = '{32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,  4'd7,  16'hFFFF,   1'b0};
    tbl[7] = '{32'hFFFF_FFFF,  32'd0,          32'd1,          4'd8,  16'hFFFF,   1'b1};
    tbl[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd9,  16'hFFFF,   1'b1};
    tbl[9] = '{32'd0,          32'd0,          32'd0,          4'hF,  16'd0,      1'b0};

    do_reset(3);

    // Directed table: first vector alone, the rest back-to-back.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].tag, tbl[i].res, tbl[i].sat);
      if (i == 0) repeat (LAT + 5) drive_idle();
    end
    drain();

    // 200 back-to-back random vectors with incrementing tags.
    tag_cnt = '0;
    for (int i = 0; i < 200; i++) drive_rand(1'b1);
    drain();

    // Random ~40% duty stream.
    for (int i = 0; i < 1000; i++) drive_rand($urandom_range(0, 99) < 40);
    drain();

    // Reset with 10 vectors still deep in the pipeline.
    for (int i = 0; i < 10; i++) drive_rand(1'b1);
    repeat (20) drive_idle();
    do_reset(3);
    repeat (LAT + 10) drive_idle();
    drive_rand(1'b1);
    drain();

    // Reset while results are emerging.
    for (int i = 0; i < 20; i++) drive_rand(1'b1);
    repeat (LAT - 17) drive_idle();
    do_reset(2);
    repeat (LAT + 10) drive_idle();
    drive_rand(1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
